// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the IF/ID pipeline bundle
package cpu_pkg;

  localparam int          XLEN          = 32;
  localparam int          IM_AW_DEFAULT = 6;
  localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;

  // IF/ID pipeline register contents, shared with the decode stage
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/ifetch_next_pc.sv
// rtl/ifetch_next_pc.sv - combinational next-PC select with redirect range check and wrap
module ifetch_next_pc
  import cpu_pkg::*;
#(
  parameter int          PROG_WORDS = 13,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc,
  output logic        range_err
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(PROG_WORDS * 4);

  logic [XLEN-1:0] seq_pc;
  logic            target_ok;

  // Redirect targets must be word aligned and inside the program image;
  // a bad target falls back to RESET_PC. Sequential fetch wraps at the end.
  always_comb begin
    seq_pc    = pc + 32'd4;
    target_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc < PC_LIMIT);
    range_err = 1'b0;
    next_pc   = (seq_pc >= PC_LIMIT) ? RESET_PC : seq_pc;
    if (redirect) begin
      next_pc   = target_ok ? redirect_pc : RESET_PC;
      range_err = !target_ok;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage: PC, IF/ID register, status; IFETCH_FETCH_CNT_EN builds fetch_cnt
module ifetch_stage
  import cpu_pkg::*;
#(
  parameter int          IM_AW      = IM_AW_DEFAULT,
  parameter int          PROG_WORDS = 13,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             step_en,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_instr,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic [31:0]      id_instr,
  output logic [31:0]      pc_o,
  output logic             err_range,
  output logic [31:0]      fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  logic        err_q, err_d;
  logic        advance;
  logic [31:0] next_pc;
  logic        range_err;

  ifetch_next_pc #(
    .PROG_WORDS (PROG_WORDS),
    .RESET_PC   (RESET_PC)
  ) u_next_pc (
    .pc          (pc_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .next_pc     (next_pc),
    .range_err   (range_err)
  );

  // Tick priority: redirect flushes IF/ID, else stall holds, else advance
  always_comb begin
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    err_d   = err_q;
    advance = 1'b0;
    if (step_en) begin
      if (redirect) begin
        pc_d         = next_pc;
        ifid_d.valid = 1'b0;
        ifid_d.instr = INSTR_NOP;
        err_d        = err_q | range_err;
      end else if (!stall) begin
        advance      = 1'b1;
        pc_d         = next_pc;
        ifid_d.valid = 1'b1;
        ifid_d.pc    = pc_q;
        ifid_d.pc4   = pc_q + 32'd4;
        ifid_d.instr = im_instr;
      end
    end
  end

  // PC, IF/ID and sticky error registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q   <= RESET_PC;
      ifid_q <= '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: INSTR_NOP};
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      err_q  <= err_d;
    end
  end

`ifdef IFETCH_FETCH_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = advance ? cnt_q + 32'd1 : cnt_q;
  end

  // Count of valid fetches, wraps modulo 2^32
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= 32'h0;
    else       cnt_q <= cnt_d;
  end

  assign fetch_cnt = cnt_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign fetch_cnt      = 32'h0;
`endif

  assign im_addr   = pc_q[IM_AW+1:2];
  assign pc_o      = pc_q;
  assign id_valid  = ifid_q.valid;
  assign id_pc     = ifid_q.pc;
  assign id_pc4    = ifid_q.pc4;
  assign id_instr  = ifid_q.instr;
  assign err_range = err_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - randomized self-checking bench for ifetch_stage against a behavioural model
module tb_ifetch_stage;

  localparam int          IM_AW      = 6;
  localparam int          PROG_WORDS = 13;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] LIMIT      = PROG_WORDS * 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             step_en, stall, redirect;
  logic [31:0]      redirect_pc;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_instr;
  logic             id_valid, err_range;
  logic [31:0]      id_pc, id_pc4, id_instr, pc_o, fetch_cnt;

  logic [31:0] rom [0:(1<<IM_AW)-1];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc, m_idpc, m_idpc4, m_instr, m_cnt;
  logic        m_valid, m_err;

  always #5 clk = ~clk;

  assign im_instr = rom[im_addr];

  ifetch_stage #(
    .IM_AW      (IM_AW),
    .PROG_WORDS (PROG_WORDS),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .step_en     (step_en),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_addr     (im_addr),
    .im_instr    (im_instr),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_instr    (id_instr),
    .pc_o        (pc_o),
    .err_range   (err_range),
    .fetch_cnt   (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_idpc = 0; m_idpc4 = 0; m_instr = NOP; m_cnt = 0;
    m_valid = 0; m_err = 0;
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ":id_valid"}, {31'h0, id_valid}, {31'h0, m_valid});
    check({ctx, ":id_pc"}, id_pc, m_idpc);
    check({ctx, ":id_pc4"}, id_pc4, m_idpc4);
    check({ctx, ":id_instr"}, id_instr, m_instr);
    check({ctx, ":pc_o"}, pc_o, m_pc);
    check({ctx, ":im_addr"}, {26'h0, im_addr}, m_pc / 4);
    check({ctx, ":err_range"}, {31'h0, err_range}, {31'h0, m_err});
`ifdef IFETCH_FETCH_CNT_EN
    check({ctx, ":fetch_cnt"}, fetch_cnt, m_cnt);
`else
    check({ctx, ":fetch_cnt"}, fetch_cnt, 32'h0);
`endif
  endtask

  // one clk cycle: drive, clock, update model, compare (sampled 1 after the edge)
  task automatic cyc(input logic s_en, input logic s_st, input logic s_rd,
                     input logic [31:0] s_rpc, input string ctx);
    step_en = s_en; stall = s_st; redirect = s_rd; redirect_pc = s_rpc;
    @(posedge clk);
    #1;
    if (s_en) begin
      if (s_rd) begin
        m_valid = 0;
        m_instr = NOP;
        if (s_rpc % 4 == 0 && s_rpc < LIMIT) m_pc = s_rpc;
        else begin
          m_pc  = 0;
          m_err = 1;
        end
      end else if (!s_st) begin
        m_idpc  = m_pc;
        m_idpc4 = m_pc + 4;
        m_instr = rom[m_pc / 4];
        m_valid = 1;
        m_cnt   = m_cnt + 1;
        m_pc    = (m_pc + 4 >= LIMIT) ? 0 : m_pc + 4;
      end
    end
    check_all(ctx);
  endtask

  function automatic logic [31:0] rand_target();
    int k;
    k = $urandom_range(0, 5);
    if (k < 3) return 32'($urandom_range(0, PROG_WORDS - 1)) * 4;
    else if (k == 3) return (32'($urandom_range(0, 20)) * 4) | 32'($urandom_range(1, 3));
    else return LIMIT + 32'($urandom_range(0, 1000)) * 4;
  endfunction

  initial begin
    int guard;
    for (int i = 0; i < (1 << IM_AW); i++) rom[i] = $urandom;
    step_en = 0; stall = 0; redirect = 0; redirect_pc = 0;
    rstn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rstn = 1;

    // straight-line fetch through the wrap
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, "seq");
    check("seq_cnt_model", m_idpc, 32'h0);

    // advance until pc=8, then stall 3 ticks, then advance
    guard = 0;
    while (m_pc != 8 && guard < 20) begin
      cyc(1, 0, 0, 0, "to8");
      guard++;
    end
    check("reach_pc8", pc_o, 32'h8);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, "stall");
    cyc(1, 0, 0, 0, "after_stall");

    // redirect with simultaneous stall at pc=16
    guard = 0;
    while (m_pc != 16 && guard < 20) begin
      cyc(1, 0, 0, 0, "to16");
      guard++;
    end
    check("reach_pc16", pc_o, 32'h10);
    cyc(1, 1, 1, 32'h4, "redir_stall");
    cyc(1, 0, 0, 0, "redir_bubble_next");
    cyc(1, 0, 0, 0, "redir_follow");

    // bad targets
    cyc(1, 0, 1, 32'h6, "redir_misaligned");
    cyc(1, 0, 0, 0, "after_bad1");
    cyc(1, 0, 1, 32'h40, "redir_oob");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, "err_sticky");

    // step_en only every 4th cycle, random control otherwise
    for (int i = 0; i < 40; i++)
      cyc((i % 4) == 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          rand_target(), "sparse");

    // fully random mix
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 7) == 0), rand_target(), "rand");

    // reset asserted mid-stall, checked before the next edge
    cyc(1, 1, 0, 0, "pre_rst_stall");
    stall = 1; step_en = 1;
    #2;
    rstn = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rstn = 1;
    cyc(0, 0, 0, 0, "post_rst_idle");
    cyc(1, 0, 0, 0, "post_rst_first");
    check("first_fetch_pc", id_pc, 32'h0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, "post_rst_seq");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the single-cycle/pipelined CPU. It owns the program counter, drives the word address of the asynchronous instruction ROM (`dist_mem_gen_0`), and registers the fetched instruction with its PC into an IF/ID register for the decode stage. It also exports the live PC and sticky status for the seven-segment debug display. It advances only on CPU-tick enables, so one fast clock serves both debug and run speeds.

## Interface
Parameters:
- `IM_AW`, 6, ROM word-address width.
- `PROG_WORDS`, 13, number of valid program words; PC wraps at `PROG_WORDS*4`.
- `RESET_PC`, 32'h0000_0000, PC after reset and after wrap; must be word aligned.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rstn`  in  1  reset. Asynchronous, active-low.
- `step_en`  in  1  CPU tick, one `clk` cycle wide; state changes only when high.
- `stall`  in  1  hold request from decode/hazard logic.
- `redirect`  in  1  taken branch/jump from EX; flushes IF/ID.
- `redirect_pc`  in  32  branch/jump target byte address.
- `im_addr`  out  IM_AW  ROM word address, equal to `pc[IM_AW+1:2]`.
- `im_instr`  in  32  ROM data, combinational from `im_addr`.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_pc`  out  32  PC of the IF/ID instruction.
- `id_pc4`  out  32  `id_pc + 4`, registered.
- `id_instr`  out  32  IF/ID instruction; NOP when invalid.
- `pc_o`  out  32  current fetch PC, for display.
- `err_range`  out  1  sticky flag: a redirect target was misaligned or out of range.
- `fetch_cnt`  out  32  count of valid fetches (see Configuration).

## Operation
- Reset values: `pc=RESET_PC`, `id_valid=0`, `id_pc=0`, `id_pc4=0`, `id_instr=32'h0000_0013` (NOP), `err_range=0`, `fetch_cnt=0`.
- Tick priority (`step_en=1`): redirect > stall > advance. With `step_en=0`, all registers hold.
- Redirect:
  - `id_valid<=0` and `id_instr<=NOP`. `id_pc` and `id_pc4` hold.
  - If the target is aligned and `< PROG_WORDS*4`: `pc<=redirect_pc`.
  - Otherwise: `pc<=RESET_PC` and `err_range<=1`.
  - Redirect overrides a simultaneous stall.
- Stall without redirect: PC and IF/ID hold. `fetch_cnt` holds.
- Advance:
  - `id_pc<=pc`, `id_pc4<=pc+4`, `id_instr<=im_instr`, `id_valid<=1`.
  - `pc<=pc+4`, or `RESET_PC` when `pc+4 >= PROG_WORDS*4` (wrap).
  - `fetch_cnt` increments, wrapping modulo 2^32.
- `err_range` clears only on reset.
- All PC arithmetic is 32-bit unsigned. Bits `pc[1:0]` are always 0.
- `im_addr` and `pc_o` are pure functions of the PC register, with no combinational path from inputs.

## Timing
- Fetch latency: the instruction at PC p appears on `id_*` at the tick after p is on `im_addr` (one tick).
- Redirect penalty: one bubble tick (`id_valid=0`). The target instruction reaches IF/ID on the following tick.
- Stall of N ticks holds `id_*` stable for exactly N ticks.
- Reset asserted mid-operation forces reset values immediately. The first fetch after release is at `RESET_PC`, on the first `step_en` tick.

## Configuration
- `IFETCH_FETCH_CNT_EN` defined: the 32-bit `fetch_cnt` counter is built as described above.
- `IFETCH_FETCH_CNT_EN` undefined: no counter is built; `fetch_cnt` is tied to 32'h0.
- All other behaviour is identical in both cases.

## Structure
- Shared package `cpu_pkg` holds:
  - `INSTR_NOP = 32'h0000_0013`.
  - `XLEN = 32`.
  - Default `IM_AW` and the IF/ID bundle typedef (`valid`, `pc`, `pc4`, `instr`), reused by the decode stage.
- One sub-module, `ifetch_next_pc`: a combinational next-PC select covering redirect, range/alignment check, sequential increment and wrap. It outputs `next_pc` and `range_err`.
- The top module keeps the PC, IF/ID and status registers.

## Test plan
- Reset, then 14 ticks with no stall/redirect → `id_pc` = 0, 4, …, 48, then 0. `id_instr` matches ROM words 0..12, then word 0. `fetch_cnt=14`.
- At `pc=8`, hold `stall` for 3 ticks → `id_pc=4` is held for 3 ticks, `pc_o=8` holds, and the next advance gives `id_pc=8`.
- At `pc=16`, pulse `redirect` with `redirect_pc=4` while `stall=1` → next tick `id_valid=0` and `id_instr=NOP`; the following tick gives `id_pc=4` and `id_valid=1`.
- Redirect to 32'h6 and, separately, to 32'h40 → `pc_o=0` and `err_range=1`, which stays 1 until `rstn` is low.
- Toggle `step_en` only every 4th cycle → state changes exactly on those cycles and holds otherwise.
- Assert `rstn` low mid-stall → outputs take reset values immediately. After release, the first tick fetches at 0. With `IFETCH_FETCH_CNT_EN` undefined, `fetch_cnt` stays 0 throughout.
